nrf_spi_master: RTL and testbench

SPI mode-0 transaction engine for the nRF24L01 link. It sequences the transceiver's SPI bus (CSN, SCK, MOSI, MISO) from the 50 MHz system clock. SCK is a registered output paced by an internal phase counter, so no derived clock domain exists. The upstream command layer supplies a byte count and streams TX bytes; the block returns one RX byte per TX byte.

---
 rtl/nrf_spi_pkg.sv | 30 +++
 rtl/nrf_spi_master_if.sv | 40 ++++
 rtl/spi_sck_tick.sv | 38 +++
 rtl/nrf_spi_master.sv | 175 +++++++++++++++++
 tb/tb_nrf_spi_master.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nrf_spi_pkg.sv
// Shared types and constants for the nRF24L01 SPI master.
// State encoding, length limits and nRF command opcodes.
package nrf_spi_pkg;

    localparam int LEN_W   = 6;
    localparam int MAX_LEN = 33;

    localparam logic [7:0] R_REGISTER   = 8'h00;
    localparam logic [7:0] W_REGISTER   = 8'h20;
    localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
    localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
    localparam logic [7:0] FLUSH_TX     = 8'hE1;
    localparam logic [7:0] FLUSH_RX     = 8'hE2;
    localparam logic [7:0] NOP          = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nrf_spi_master_if.sv
// Command-side and SPI-pin bundle of the nRF SPI master.
// Status ports exist only with NRF_STATUS_CAPTURE_EN.
interface nrf_spi_master_if;

    logic                         start;
    logic [nrf_spi_pkg::LEN_W-1:0] len;
    logic [7:0]                   tx_data;
    logic                         tx_load;
    logic [7:0]                   rx_data;
    logic                         rx_valid;
    logic                         busy;
    logic                         done;
    logic                         spi_csn;
    logic                         spi_sck;
    logic                         spi_mosi;
    logic                         spi_miso;
`ifdef NRF_STATUS_CAPTURE_EN
    logic [7:0]                   status;
    logic                         status_valid;
`endif

    modport master (
        input  start, len, tx_data, spi_miso,
`ifdef NRF_STATUS_CAPTURE_EN
        output status, status_valid,
`endif
        output tx_load, rx_data, rx_valid, busy, done,
        output spi_csn, spi_sck, spi_mosi
    );

    modport slave (
        output start, len, tx_data, spi_miso,
`ifdef NRF_STATUS_CAPTURE_EN
        input  status, status_valid,
`endif
        input  tx_load, rx_data, rx_valid, busy, done,
        input  spi_csn, spi_sck, spi_mosi
    );

endinterface

// File: rtl/spi_sck_tick.sv
// SCK phase counter: toggles sck every CLK_DIV enabled cycles.
// rise_tick/fall_tick flag the cycle before sck goes high/low.
module spi_sck_tick #(
    parameter int CLK_DIV = 3
) (
    input  logic clk_50,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic rise_tick,
    output logic fall_tick,
    output logic sck
);

    localparam int PH_W = $clog2(CLK_DIV);

    logic [PH_W-1:0] ph;
    logic            term;

    assign term      = en && (ph == PH_W'(CLK_DIV - 1));
    assign rise_tick = term && !sck;
    assign fall_tick = term && sck;

    always_ff @(posedge clk_50) begin
        if (rst || clr) begin
            ph  <= '0;
            sck <= 1'b0;
        end else if (en) begin
            if (term) begin
                ph  <= '0;
                sck <= ~sck;
            end else begin
                ph <= ph + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/nrf_spi_master.sv
// nRF24L01 SPI mode-0 master; SCK is paced inside the clk_50 domain.
// Define NRF_STATUS_CAPTURE_EN to latch the first RX byte as status.
module nrf_spi_master
    import nrf_spi_pkg::*;
#(
    parameter int CLK_DIV   = 3,
    parameter int CSN_SETUP = 2,
    parameter int CSN_HOLD  = 2,
    parameter int CSN_GAP   = 3
) (
    input logic              clk_50,
    input logic              rst,
    nrf_spi_master_if.master bus
);

    localparam int CSN_W = $clog2(max3(CSN_SETUP, CSN_HOLD, CSN_GAP)) + 1;

    state_t           state;
    logic [CSN_W-1:0] cnt;
    logic [LEN_W-1:0] rem;
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       rx_data_q;
    logic             csn_q;
    logic             busy_q;
    logic             done_q;
    logic             rx_valid_q;
    logic             tx_reload;
    logic             accept;
    logic             sck_en;
    logic             rise_tick;
    logic             fall_tick;
    logic             sck;
    logic             byte_end;

    assign accept   = !rst && state == ST_IDLE && bus.start && bus.len != '0;
    assign sck_en   = state == ST_SHIFT;
    assign byte_end = fall_tick && bit_cnt == 3'd7;

    spi_sck_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_50    (clk_50),
        .rst       (rst),
        .en        (sck_en),
        .clr       (!sck_en),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sck       (sck)
    );

    assign bus.tx_load  = accept | tx_reload;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.spi_csn  = csn_q;
    assign bus.spi_sck  = sck;
    assign bus.spi_mosi = tx_sr[7];

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            csn_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_reload  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_reload  <= 1'b0;
            done_q     <= 1'b0;
            if (bus.tx_load) tx_sr <= bus.tx_data;
            else if (fall_tick) tx_sr <= {tx_sr[6:0], 1'b0};
            if (rise_tick) rx_sr <= {rx_sr[6:0], bus.spi_miso};
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_SETUP;
                        rem    <= bus.len;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        csn_q  <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CSN_W'(CSN_SETUP - 1)) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + CSN_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (fall_tick) bit_cnt <= bit_cnt + 3'd1;
                    if (byte_end) begin
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sr;
                        // Exit is decided before decrementing so rem never wraps.
                        if (rem == LEN_W'(1)) begin
                            rem   <= '0;
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            rem       <= rem - LEN_W'(1);
                            tx_reload <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == CSN_W'(CSN_HOLD - 1)) begin
                        cnt   <= '0;
                        csn_q <= 1'b1;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + CSN_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CSN_W'(CSN_GAP - 1)) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt    <= cnt + CSN_W'(1);
                        done_q <= (cnt == CSN_W'(CSN_GAP - 2));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef NRF_STATUS_CAPTURE_EN
    logic       first_q;
    logic [7:0] status_q;
    logic       status_valid_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            first_q        <= 1'b0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            if (accept) begin
                first_q <= 1'b1;
            end else if (byte_end && first_q) begin
                first_q        <= 1'b0;
                status_q       <= rx_sr;
                status_valid_q <= 1'b1;
            end
        end
    end

    assign bus.status       = status_q;
    assign bus.status_valid = status_valid_q;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_50) begin
        if (accept) begin
            assert (bus.len <= LEN_W'(MAX_LEN))
            else $error("nrf_spi_master: len %0d above %0d", bus.len, MAX_LEN);
        end
    end
`endif

endmodule

// File: tb/tb_nrf_spi_master.sv
// Directed bench for nrf_spi_master with a mode-0 MISO slave model.
// Status checks are added when NRF_STATUS_CAPTURE_EN is defined.
module tb_nrf_spi_master;
    import nrf_spi_pkg::*;

    localparam int CLK_DIV = 3;

    logic clk_50 = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t0      = 0;

    nrf_spi_master_if bus ();

    nrf_spi_master #(
        .CLK_DIV   (CLK_DIV),
        .CSN_SETUP (2),
        .CSN_HOLD  (2),
        .CSN_GAP   (3)
    ) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    // show-ahead TX source
    logic [7:0] tx_tab   [64];
    logic [7:0] miso_tab [64];
    int tx_cnt  = 0;
    int tx_base = 0;
    always @(posedge clk_50) if (bus.tx_load) tx_cnt <= tx_cnt + 1;
    assign bus.tx_data = tx_tab[(tx_cnt - tx_base) & 63];

    // mode-0 slave: new bit after each SCK fall, first byte on CSN fall
    logic [7:0] msr = 8'h00;
    int   mn = 0;
    int   mb = 0;
    logic csn_d = 1'b1;
    logic sck_d = 1'b0;
    always @(posedge clk_50) begin
        csn_d <= bus.spi_csn;
        sck_d <= bus.spi_sck;
        if (csn_d && !bus.spi_csn) begin
            msr <= miso_tab[0];
            mn  <= 1;
            mb  <= 0;
        end else if (sck_d && !bus.spi_sck) begin
            if (mb == 7) begin
                msr <= miso_tab[mn & 63];
                mn  <= mn + 1;
                mb  <= 0;
            end else begin
                msr <= msr << 1;
                mb  <= mb + 1;
            end
        end
    end
    assign bus.spi_miso = msr[7];

    // event monitor, sampled on the falling clock edge
    logic       sck_p = 1'b0;
    logic       csn_p = 1'b1;
    logic       win   = 1'b0;
    logic [7:0] mosi_sr = 8'h00;
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    int hi_len = 0, lo_len = 0, hi_bad = 0, gap_bad = 0;
    int rises = 0, csn_falls = 0, busy_cyc = 0;
    int txl_cnt = 0, rxv_cnt = 0, done_cnt = 0, done_cyc = 0;
`ifdef NRF_STATUS_CAPTURE_EN
    int         sv_cnt = 0, sv_rxv = 0, sv_alone = 0;
    logic [7:0] sv_val = 8'h00;
`endif

    always @(negedge clk_50) begin
        sck_p  <= bus.spi_sck;
        csn_p  <= bus.spi_csn;
        hi_len <= bus.spi_sck ? hi_len + 1 : 0;
        lo_len <= bus.spi_sck ? 0 : lo_len + 1;
        if (!bus.spi_sck && sck_p && hi_len != CLK_DIV) hi_bad <= hi_bad + 1;
        if (bus.spi_sck && !sck_p) begin
            rises   <= rises + 1;
            mosi_sr <= {mosi_sr[6:0], bus.spi_mosi};
            if (win && lo_len != CLK_DIV) gap_bad <= gap_bad + 1;
        end
        if (bus.spi_csn) win <= 1'b0;
        else if (bus.spi_sck && !sck_p) win <= 1'b1;
        if (!bus.spi_csn && csn_p) csn_falls <= csn_falls + 1;
        if (bus.busy) busy_cyc <= busy_cyc + 1;
        if (bus.tx_load) txl_cnt <= txl_cnt + 1;
        if (bus.rx_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rx_q.push_back(bus.rx_data);
            tx_q.push_back(mosi_sr);
        end
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
`ifdef NRF_STATUS_CAPTURE_EN
        if (bus.status_valid) begin
            sv_cnt <= sv_cnt + 1;
            sv_rxv <= rxv_cnt;
            sv_val <= bus.status;
            if (!bus.rx_valid) sv_alone <= sv_alone + 1;
        end
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic go(input int n);
        step(1);
        tx_base   = tx_cnt;
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        t0        = cyc;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.busy && n < lim) begin
            step(1);
            n++;
        end
        chk("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    int r0, q0, s0, d0, x0, c0, b0, h0, g0;

    initial begin
        bus.start = 1'b0;
        bus.len   = '0;
        for (int i = 0; i < 64; i++) begin
            tx_tab[i]   = 8'h00;
            miso_tab[i] = 8'h00;
        end
        step(3);
        rst = 1'b0;
        step(1);

        chk("rst_csn", bus.spi_csn, 1);
        chk("rst_sck", bus.spi_sck, 0);
        chk("rst_mosi", bus.spi_mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tx_load", bus.tx_load, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 8'h00);
`ifdef NRF_STATUS_CAPTURE_EN
        chk("rst_status", bus.status, 8'h00);
`endif

        // single byte: A5 out, 3C in
        tx_tab[0] = 8'hA5;
        miso_tab[0] = 8'h3C;
        r0 = rxv_cnt; q0 = rx_q.size(); s0 = rises; h0 = hi_bad;
        d0 = done_cnt; x0 = txl_cnt;
        go(1);
        chk("t1_busy_T1", bus.busy, 1);
        chk("t1_csn_T1", bus.spi_csn, 0);
        wait_idle(200);
        chk("t1_rxv_cnt", rxv_cnt - r0, 1);
        chk("t1_rx_byte", rx_q[q0], 8'h3C);
        chk("t1_mosi_bits", tx_q[q0], 8'hA5);
        chk("t1_rx_hold", bus.rx_data, 8'h3C);
        chk("t1_sck_rises", rises - s0, 8);
        chk("t1_sck_high", hi_bad - h0, 0);
        chk("t1_tx_load", txl_cnt - x0, 1);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_latency", done_cyc - t0, 55);

        // 33-byte burst, MISO echoes previous TX byte
        for (int i = 0; i < 33; i++) begin
            tx_tab[i]   = 8'(i);
            miso_tab[i] = (i == 0) ? 8'h5A : 8'(i - 1);
        end
        r0 = rxv_cnt; q0 = rx_q.size(); s0 = rises; g0 = gap_bad;
        c0 = csn_falls; x0 = txl_cnt; d0 = done_cnt;
        go(33);
        wait_idle(3000);
        chk("t2_tx_load", txl_cnt - x0, 33);
        chk("t2_rx_valid", rxv_cnt - r0, 33);
        chk("t2_sck_rises", rises - s0, 264);
        chk("t2_sck_gaps", gap_bad - g0, 0);
        chk("t2_csn_window", csn_falls - c0, 1);
        chk("t2_latency", done_cyc - t0, 1591);
        for (int i = 0; i < 33; i++) begin
            chk("t2_mosi_byte", tx_q[q0 + i], 32'(i));
            chk("t2_rx_byte", rx_q[q0 + i], (i == 0) ? 32'h5A : 32'(i - 1));
        end

        // start during SHIFT and in the done cycle
        tx_tab[0] = NOP;
        miso_tab[0] = 8'h0E;
        d0 = done_cnt; x0 = txl_cnt; c0 = csn_falls;
        go(1);
        step(20);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        at_cyc(t0 + 55);
        chk("t3_done_cycle", bus.done, 1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(80);
        chk("t3_done_cnt", done_cnt - d0, 1);
        chk("t3_latency", done_cyc - t0, 55);
        chk("t3_tx_load", txl_cnt - x0, 1);
        chk("t3_csn_falls", csn_falls - c0, 1);
        chk("t3_busy", bus.busy, 0);

        // len=0 is ignored
        c0 = csn_falls; s0 = rises; b0 = busy_cyc; x0 = txl_cnt;
        bus.len = '0;
        bus.start = 1'b1;
        step(20);
        chk("t4_busy", bus.busy, 0);
        chk("t4_csn", bus.spi_csn, 1);
        bus.start = 1'b0;
        step(2);
        chk("t4_busy_cyc", busy_cyc - b0, 0);
        chk("t4_csn_falls", csn_falls - c0, 0);
        chk("t4_sck_rises", rises - s0, 0);
        chk("t4_tx_load", txl_cnt - x0, 0);

        // reset in byte 3 of 5, then a clean len=2 transfer
        tx_tab[0] = W_TX_PAYLOAD;
        for (int i = 1; i < 5; i++) tx_tab[i] = 8'(i);
        r0 = rxv_cnt; d0 = done_cnt;
        go(5);
        at_cyc(t0 + 2 + 96 + 20);
        chk("t5_pre_rxv", rxv_cnt - r0, 2);
        rst = 1'b1;
        step(1);
        chk("t5_rst_csn", bus.spi_csn, 1);
        chk("t5_rst_sck", bus.spi_sck, 0);
        chk("t5_rst_busy", bus.busy, 0);
        rst = 1'b0;
        step(5);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_no_rxv", rxv_cnt - r0, 2);
        chk("t5_rx_data", bus.rx_data, 8'h00);
        tx_tab[0] = 8'h11; tx_tab[1] = 8'h22;
        miso_tab[0] = 8'h33; miso_tab[1] = 8'h44;
        r0 = rxv_cnt; q0 = rx_q.size(); d0 = done_cnt;
        go(2);
        wait_idle(400);
        chk("t5_rxv", rxv_cnt - r0, 2);
        chk("t5_rx0", rx_q[q0], 8'h33);
        chk("t5_rx1", rx_q[q0 + 1], 8'h44);
        chk("t5_tx1", tx_q[q0 + 1], 8'h22);
        chk("t5_done", done_cnt - d0, 1);
        chk("t5_latency", done_cyc - t0, 103);

`ifdef NRF_STATUS_CAPTURE_EN
        tx_tab[0] = R_REGISTER; tx_tab[1] = NOP; tx_tab[2] = NOP;
        miso_tab[0] = 8'h0E; miso_tab[1] = 8'h77; miso_tab[2] = 8'h55;
        r0 = rxv_cnt; s0 = sv_cnt; g0 = sv_alone;
        go(3);
        wait_idle(400);
        chk("t6_status", bus.status, 8'h0E);
        chk("t6_sv_cnt", sv_cnt - s0, 1);
        chk("t6_sv_first", sv_rxv, r0);
        chk("t6_sv_align", sv_alone - g0, 0);
        chk("t6_sv_val", sv_val, 8'h0E);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
